// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART byte strobe and the CPU register block: first-word-fall-through,
// with ready/full/overrun status. Optional hysteretic rts_n flow control under UART_RX_FIFO_RTS_EN.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned RTS_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  wr_strb,
  input  logic [7:0]            wr_data,
  input  logic                  rd_strb,
  input  logic                  ovr_clr,
  output logic [7:0]            rd_data,
  output logic                  rdy,
  output logic                  ful,
  output logic                  ovr,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  rts_n
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_rd_data;
  logic          r_rdy;
  logic          r_ful;
  logic          r_ovr;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [7:0]    w_rd_data_nxt;
  logic          w_ovr_nxt;

  if (RTS_THRESH > DEPTH) begin : g_rts_thresh_check
    $error("RTS_THRESH exceeds FIFO depth");
  end

  // Push/pop qualification and next-state for pointers, occupancy, head byte and overrun.
  always_comb begin
    w_empty      = (r_count == '0);
    w_full       = (r_count == FULL_CNT);
    w_pop        = rd_strb & clken & ~w_empty;
    w_push       = wr_strb & (~w_full | w_pop);
    w_drop       = wr_strb & w_full & ~w_pop;
    w_wr_ptr_nxt = r_wr_ptr + AW'(w_push);
    w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
    w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
    w_rd_data_nxt = r_rd_data;
    // New head is the byte being written this cycle when the FIFO is (or just became) empty.
    if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
      w_rd_data_nxt = wr_data;
    end else if (w_count_nxt != '0) begin
      w_rd_data_nxt = r_mem[w_rd_ptr_nxt];
    end
    w_ovr_nxt = r_ovr;
    if (w_drop) begin
      w_ovr_nxt = 1'b1;
    end else if (ovr_clr && clken) begin
      w_ovr_nxt = 1'b0;
    end
  end

  // Storage is not reset; its contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= 8'h00;
      r_rdy     <= 1'b0;
      r_ful     <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_count   <= w_count_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_rdy     <= (w_count_nxt != '0);
      r_ful     <= (w_count_nxt == FULL_CNT);
      r_ovr     <= w_ovr_nxt;
    end
  end

`ifdef UART_RX_FIFO_RTS_EN
  localparam logic [CW-1:0] RTS_HI = CW'(RTS_THRESH);
  localparam logic [CW-1:0] RTS_LO = CW'(RTS_THRESH / 2);

  logic r_rts_n;

  // Hysteresis: deassert at the high-water mark, reassert only once drained to half of it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rts_n <= 1'b0;
    end else if (r_count >= RTS_HI) begin
      r_rts_n <= 1'b1;
    end else if (r_count <= RTS_LO) begin
      r_rts_n <= 1'b0;
    end
  end

  assign rts_n = r_rts_n;
`else
  assign rts_n = 1'b0;
`endif

  assign rd_data = r_rd_data;
  assign rdy     = r_rdy;
  assign ful     = r_ful;
  assign ovr     = r_ovr;
  assign count   = r_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo; rts_n expectations follow UART_RX_FIFO_RTS_EN.
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_RTS_EN
  localparam bit RTS_EN = 1'b1;
`else
  localparam bit RTS_EN = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       clken;
  logic       wr_strb;
  logic [7:0] wr_data;
  logic       rd_strb;
  logic       ovr_clr;
  logic [7:0] rd_data;
  logic       rdy;
  logic       ful;
  logic       ovr;
  logic [4:0] count;
  logic       rts_n;

  int n_cmp;
  int n_bad;

  uart_rx_fifo #(.DEPTH_LOG2(4), .RTS_THRESH(12)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clken   (clken),
    .wr_strb (wr_strb),
    .wr_data (wr_data),
    .rd_strb (rd_strb),
    .ovr_clr (ovr_clr),
    .rd_data (rd_data),
    .rdy     (rdy),
    .ful     (ful),
    .ovr     (ovr),
    .count   (count),
    .rts_n   (rts_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_strb = 1'b1;
    wr_data = b;
    tick();
    wr_strb = 1'b0;
  endtask

  task automatic pop();
    rd_strb = 1'b1;
    clken   = 1'b1;
    tick();
    rd_strb = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy got %b want 0", rdy); end
    n_cmp++; if (ful !== 1'b0) begin n_bad++; $display("FAIL reset_ful got %b want 0", ful); end
    n_cmp++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL reset_ovr got %b want 0", ovr); end
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    n_cmp++; if (rts_n !== 1'b0) begin n_bad++; $display("FAIL reset_rts_n got %b want 0", rts_n); end
  endtask

  task automatic test_single();
    push(8'hA5);
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL single_rdy got %b want 1", rdy); end
    n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL single_count got %0d want 1", count); end
    n_cmp++; if (rd_data !== 8'hA5) begin n_bad++; $display("FAIL single_data got %h want a5", rd_data); end
    pop();
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL single_pop_rdy got %b want 0", rdy); end
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL single_pop_count got %0d want 0", count); end
    n_cmp++; if (rd_data !== 8'hA5) begin n_bad++; $display("FAIL single_hold_data got %h want a5", rd_data); end
    pop();
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL empty_pop_count got %0d want 0", count); end
  endtask

  task automatic test_fill_wrap();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) push(8'(r * 16 + i));
      n_cmp++; if (ful !== 1'b1) begin n_bad++; $display("FAIL fill_ful round %0d got %b want 1", r, ful); end
      n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL fill_count round %0d got %0d want 16", r, count); end
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (rd_data !== 8'(r * 16 + i)) begin
          n_bad++; $display("FAIL fill_order round %0d idx %0d got %h want %h", r, i, rd_data, 8'(r * 16 + i));
        end
        pop();
      end
      n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL drain_rdy round %0d got %b want 0", r, rdy); end
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'hEE);
    n_cmp++; if (ovr !== 1'b1) begin n_bad++; $display("FAIL ovr_set got %b want 1", ovr); end
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL ovr_count got %0d want 16", count); end
    n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL ovr_head got %h want 00", rd_data); end
    ovr_clr = 1'b1; clken = 1'b0;
    tick();
    n_cmp++; if (ovr !== 1'b1) begin n_bad++; $display("FAIL ovr_clr_gated got %b want 1", ovr); end
    clken = 1'b1;
    tick();
    ovr_clr = 1'b0;
    n_cmp++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL ovr_clr got %b want 0", ovr); end
    wr_strb = 1'b1; wr_data = 8'hEE; ovr_clr = 1'b1;
    tick();
    wr_strb = 1'b0; ovr_clr = 1'b0;
    n_cmp++; if (ovr !== 1'b1) begin n_bad++; $display("FAIL ovr_set_wins got %b want 1", ovr); end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (rd_data !== 8'(i)) begin n_bad++; $display("FAIL ovr_drain idx %0d got %h want %h", i, rd_data, 8'(i)); end
      pop();
    end
  endtask

  task automatic test_simul();
    for (int i = 0; i < 16; i++) push(8'(i));
    wr_strb = 1'b1; wr_data = 8'h55; rd_strb = 1'b1; clken = 1'b1;
    tick();
    wr_strb = 1'b0; rd_strb = 1'b0;
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL simul_full_count got %0d want 16", count); end
    n_cmp++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL simul_full_ovr got %b want 0", ovr); end
    for (int i = 1; i < 17; i++) begin
      n_cmp++;
      if (rd_data !== ((i == 16) ? 8'h55 : 8'(i))) begin
        n_bad++; $display("FAIL simul_full_order idx %0d got %h", i, rd_data);
      end
      pop();
    end
    wr_strb = 1'b1; wr_data = 8'h77; rd_strb = 1'b1;
    tick();
    wr_strb = 1'b0; rd_strb = 1'b0;
    n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL simul_empty_count got %0d want 1", count); end
    n_cmp++; if (rd_data !== 8'h77) begin n_bad++; $display("FAIL simul_empty_data got %h want 77", rd_data); end
    push(8'h88);
    wr_strb = 1'b1; wr_data = 8'h99; rd_strb = 1'b1;
    tick();
    wr_strb = 1'b0; rd_strb = 1'b0;
    n_cmp++; if (count !== 5'd2) begin n_bad++; $display("FAIL simul_mid_count got %0d want 2", count); end
    n_cmp++; if (rd_data !== 8'h88) begin n_bad++; $display("FAIL simul_mid_data got %h want 88", rd_data); end
    pop(); pop();
  endtask

  task automatic test_rts();
    for (int i = 0; i < 12; i++) push(8'(8'hC0 + i));
    tick();
    n_cmp++; if (rts_n !== RTS_EN) begin n_bad++; $display("FAIL rts_at_12 got %b want %b", rts_n, RTS_EN); end
    repeat (5) pop();
    tick();
    n_cmp++; if (count !== 5'd7) begin n_bad++; $display("FAIL rts_count7 got %0d want 7", count); end
    n_cmp++; if (rts_n !== RTS_EN) begin n_bad++; $display("FAIL rts_at_7 got %b want %b", rts_n, RTS_EN); end
    pop();
    tick();
    n_cmp++; if (rts_n !== 1'b0) begin n_bad++; $display("FAIL rts_at_6 got %b want 0", rts_n); end
  endtask

  task automatic test_reset_mid();
    push(8'h11); push(8'h22); push(8'h33);
    reset_n = 1'b0;
    #2;
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL async_reset_count got %0d want 0", count); end
    tick();
    reset_n = 1'b1;
    tick();
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL reset_mid_rdy got %b want 0", rdy); end
    n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_mid_data got %h want 00", rd_data); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset_n = 1'b0; clken = 1'b1; wr_strb = 1'b0; wr_data = 8'h00;
    rd_strb = 1'b0; ovr_clr = 1'b0;
    test_reset();
    test_single();
    test_fill_wrap();
    test_overrun();
    test_simul();
    test_rts();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
